// File: rtl/seg7_scan4_if.sv
// Digit-set input and multiplexed display output bundle for the 4-digit scanner.
// load is a strobe with no back-pressure. Every rising edge with load=1 captures
// A..D and dp. The scanner is always ready, so the interface has no ready signal.
interface seg7_scan4_if;
    logic       load;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [3:0] D;
    logic [3:0] dp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame;
    logic [1:0] dbg_idx;

    modport master (
        output load, A, B, C, D, dp,
        input  an, seg, dp_n, frame, dbg_idx
    );

    modport slave (
        input  load, A, B, C, D, dp,
        output an, seg, dp_n, frame, dbg_idx
    );
endinterface

// File: rtl/seg7_scan4.sv
// Four-digit common-anode 7-segment scanner with a shadow capture register,
// leading-zero blanking, and dead-time between digit slots.
module seg7_scan4 #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic         clk,
    input  logic         rst,
    seg7_scan4_if.slave  bus
);
    typedef logic [3:0] nib_t;

    nib_t        shadow_q [4];
    nib_t        shadow_d [4];
    nib_t        cap      [4];
    logic [3:0]  sdp_q, sdp_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dpn_q, dpn_d;
    logic        frame_q, frame_d;
    logic        terminal;

    function automatic logic [6:0] decode(input nib_t v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hF:    s = 7'h7F;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // A zero is blanked only if every more-significant digit is already blank.
    always_comb begin
        cap[0] = bus.A;
        cap[1] = bus.B;
        cap[2] = bus.C;
        cap[3] = bus.D;
        if (LZ_BLANK != 0) begin
            if (cap[3] == 4'h0) cap[3] = 4'hF;
            if (cap[2] == 4'h0 && cap[3] == 4'hF) cap[2] = 4'hF;
            if (cap[1] == 4'h0 && cap[2] == 4'hF) cap[1] = 4'hF;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        if (bus.load) begin
            shadow_d = cap;
            sdp_d    = bus.dp;
        end

        terminal = (presc_q == 16'(PRESCALE - 1));
        presc_d  = terminal ? 16'd0 : presc_q + 16'd1;
        idx_d    = terminal ? idx_q + 2'd1 : idx_q;
        frame_d  = terminal && (idx_q == 2'd3);

        // Anodes follow the incoming prescaler value, so they line up with the slot.
        an_d = 4'hF;
        if (presc_d >= 16'(BLANK_CYCLES)) an_d[idx_d] = 1'b0;

        seg_d = decode(shadow_q[idx_q]);
        dpn_d = ~sdp_q[idx_q];
        if (shadow_q[idx_q] == 4'hF && !sdp_q[idx_q]) dpn_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '{default: 4'hF};
            sdp_q    <= 4'h0;
            presc_q  <= 16'd0;
            idx_q    <= 2'd0;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            dpn_q    <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dpn_q    <= dpn_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp_n    = dpn_q;
    assign bus.frame   = frame_q;
    assign bus.dbg_idx = idx_q;
endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboard bench for seg7_scan4: two instances, with and without leading-zero
// blanking, checked every cycle against a time-based model of the scan.
module tb_seg7_scan4;
    localparam int P  = 8;
    localparam int BC = 2;

    typedef logic [3:0][3:0] dig_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seg7_scan4_if i1 ();
    seg7_scan4_if i0 ();

    seg7_scan4 #(.PRESCALE(P), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dut_lz1 (
        .clk (clk),
        .rst (rst),
        .bus (i1)
    );

    seg7_scan4 #(.PRESCALE(P), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dut_lz0 (
        .clk (clk),
        .rst (rst),
        .bus (i0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [12:0] exp1_q[$];
    logic [12:0] exp0_q[$];
    int unsigned m_t;
    dig_t        m_sh1;
    dig_t        m_sh0;
    logic [3:0]  m_dp;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hF: return 7'h7F;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic dig_t lz_fix(input dig_t v, input bit lz);
        dig_t r;
        r = v;
        if (lz) begin
            if (r[3] == 4'h0) r[3] = 4'hF;
            if (r[2] == 4'h0 && r[3] == 4'hF) r[2] = 4'hF;
            if (r[1] == 4'h0 && r[2] == 4'hF) r[1] = 4'hF;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got {an,seg,dp_n,frame}=%h expected %h", tag, m_t, got, exp);
        end
    endtask

    task automatic drive(input dig_t v, input logic [3:0] dp, input logic ld);
        i1.A = v[0]; i1.B = v[1]; i1.C = v[2]; i1.D = v[3]; i1.dp = dp; i1.load = ld;
        i0.A = v[0]; i0.B = v[1]; i0.C = v[2]; i0.D = v[3]; i0.dp = dp; i0.load = ld;
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_sh1 = {4{4'hF}};
        m_sh0 = {4{4'hF}};
        m_dp  = 4'h0;
    endtask

    // One clock: predict outputs at the edge, compare at the following falling edge.
    task automatic step();
        int unsigned sp, slot, pos;
        logic [6:0]  s1, s0;
        logic        dn1, dn0, fr;
        logic [3:0]  an;
        dig_t        in_v;
        @(posedge clk);
        sp  = (m_t / P) % 4;
        s1  = seg_of(m_sh1[sp]);
        s0  = seg_of(m_sh0[sp]);
        dn1 = ~m_dp[sp];
        dn0 = ~m_dp[sp];
        if (i1.load) begin
            in_v  = {i1.D, i1.C, i1.B, i1.A};
            m_sh1 = lz_fix(in_v, 1'b1);
            m_sh0 = lz_fix(in_v, 1'b0);
            m_dp  = i1.dp;
        end
        m_t++;
        pos  = m_t % P;
        slot = (m_t / P) % 4;
        an   = (pos < BC) ? 4'hF : ~(4'b0001 << slot);
        fr   = (m_t % (4 * P)) == 0;
        exp1_q.push_back({an, s1, dn1, fr});
        exp0_q.push_back({an, s0, dn0, fr});
        @(negedge clk);
        check("lz1", {i1.an, i1.seg, i1.dp_n, i1.frame}, exp1_q.pop_front());
        check("lz0", {i0.an, i0.seg, i0.dp_n, i0.frame}, exp0_q.pop_front());
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic load_pulse(input dig_t v, input logic [3:0] dp);
        drive(v, dp, 1'b1);
        step();
        drive(v, dp, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lz1"}, {i1.an, i1.seg, i1.dp_n, i1.frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
        check({tag, "_lz0"}, {i0.an, i0.seg, i0.dp_n, i0.frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        drive({4{4'h0}}, 4'h0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Free run with the shadow blank: anode walk and frame spacing.
        run(70);

        load_pulse({4'h1, 4'h2, 4'h3, 4'h4}, 4'h0);
        run(36);
        load_pulse({4'h0, 4'h0, 4'h0, 4'h7}, 4'h0);
        run(34);
        load_pulse({4'h0, 4'h0, 4'h0, 4'h0}, 4'h0);
        run(33);
        load_pulse({4'h0, 4'h5, 4'h0, 4'h0}, 4'b0100);
        run(34);
        load_pulse({4'hF, 4'hF, 4'hF, 4'hF}, 4'h0);
        run(33);
        load_pulse({4'hF, 4'hB, 4'hF, 4'hF}, 4'h0);
        run(33);

        // Capture on the same edge as a slot change.
        for (int k = 0; k < P && (m_t % P) != (P - 1); k++) step();
        load_pulse({4'h9, 4'h8, 4'h6, 4'h0}, 4'b1001);
        run(33);

        // Load held high with a new value every cycle.
        for (int k = 0; k < 6; k++) begin
            drive({4'(k), 4'(k + 1), 4'(k + 2), 4'(k + 3)}, 4'(k), 1'b1);
            step();
        end
        drive({4{4'h0}}, 4'h0, 1'b0);
        run(33);

        for (int k = 0; k < 8; k++) begin
            run($urandom_range(0, 20));
            load_pulse({4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
                       4'($urandom_range(0, 15)));
        end
        load_pulse({4'h3, 4'h0, 4'h2, 4'h1}, 4'h2);
        run(10);

        // Asynchronous reset while digit 3 is lit.
        for (int k = 0; k < 4 * P && (m_t % (4 * P)) != 28; k++) step();
        check("an_before_rst", {i1.an, 9'h000}, {4'b0111, 9'h000});
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b1;
        model_reset();
        run(70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
